// File: rtl/clock_enable_monitor.sv
// Clock-enable strobe health monitor: measures strobe spacing, locks, flags missing/extra strobes.
// Ports: clk, rst (async high), en_in, clear -> locked, fault, missing_pulse, extra_pulse,
// period_last, err_count, period_min/period_max (CLOCK_ENABLE_MONITOR_JITTER_STATS_EN).
module clock_enable_monitor #(
  parameter int unsigned EXPECTED_PERIOD = 31250,
  parameter int unsigned TOLERANCE       = 2,
  parameter int unsigned LOCK_COUNT      = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en_in,
  input  logic        clear,
  output logic        locked,
  output logic        fault,
  output logic        missing_pulse,
  output logic        extra_pulse,
  output logic [15:0] period_last,
  output logic [7:0]  err_count,
  output logic [15:0] period_min,
  output logic [15:0] period_max
);

  localparam logic [16:0] WIN_LO = 17'(EXPECTED_PERIOD - TOLERANCE);
  localparam logic [16:0] WIN_HI = 17'(EXPECTED_PERIOD + TOLERANCE);
  localparam logic [15:0] MISS_CNT = 16'(EXPECTED_PERIOD + TOLERANCE);
  localparam logic [3:0]  LOCK_N = 4'(LOCK_COUNT);

  typedef enum logic [1:0] {
    IDLE,
    ACQUIRE,
    LOCKED
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [15:0] cnt;
  logic [3:0]  good_cnt;
  logic [3:0]  good_nx;
  logic [16:0] p_m;
  logic        good;
  logic        early;
  logic        miss_ev;
  logic        extra_ev;
  logic        err_ev;
  logic        meas;

  assign p_m   = {1'b0, cnt} + 17'd1;
  assign good  = (p_m >= WIN_LO) && (p_m <= WIN_HI);
  assign early = (p_m < WIN_LO);
  assign err_ev = miss_ev | extra_ev;
  assign meas  = en_in && (state != IDLE);

  always_comb begin
    state_nx = state;
    good_nx  = good_cnt;
    miss_ev  = 1'b0;
    extra_ev = 1'b0;
    unique case (state)
      IDLE: begin
        if (en_in) begin
          state_nx = ACQUIRE;
          good_nx  = 4'd0;
        end
      end
      ACQUIRE: begin
        if (en_in) begin
          if (good) begin
            if (good_cnt + 4'd1 == LOCK_N) begin
              state_nx = LOCKED;
              good_nx  = 4'd0;
            end else begin
              good_nx = good_cnt + 4'd1;
            end
          end else begin
            good_nx = 4'd0;
          end
        end else if (cnt == 16'hFFFF) begin
          state_nx = IDLE;
          good_nx  = 4'd0;
        end
      end
      LOCKED: begin
        // A strobe landing exactly here is already late, so it is
        // reported as missing just like the no-strobe case.
        if (cnt == MISS_CNT) begin
          miss_ev  = 1'b1;
          state_nx = ACQUIRE;
          good_nx  = 4'd0;
        end else if (en_in && early) begin
          extra_ev = 1'b1;
          state_nx = ACQUIRE;
          good_nx  = 4'd0;
        end
      end
      default: begin
        state_nx = IDLE;
        good_nx  = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      good_cnt <= 4'd0;
      cnt      <= 16'd0;
    end else begin
      state    <= state_nx;
      good_cnt <= good_nx;
      if (en_in) begin
        cnt <= 16'd0;
      end else if (cnt != 16'hFFFF) begin
        cnt <= cnt + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      locked        <= 1'b0;
      fault         <= 1'b0;
      missing_pulse <= 1'b0;
      extra_pulse   <= 1'b0;
      period_last   <= 16'd0;
      err_count     <= 8'd0;
    end else begin
      locked        <= (state_nx == LOCKED);
      missing_pulse <= miss_ev;
      extra_pulse   <= extra_ev;
      if (meas) begin
        period_last <= p_m[16] ? 16'hFFFF : p_m[15:0];
      end
      if (err_ev) begin
        fault <= 1'b1;
        if (clear) begin
          err_count <= 8'd1;
        end else if (err_count != 8'hFF) begin
          err_count <= err_count + 8'd1;
        end
      end else if (clear) begin
        fault     <= 1'b0;
        err_count <= 8'd0;
      end
    end
  end

`ifdef CLOCK_ENABLE_MONITOR_JITTER_STATS_EN
  logic        stat_upd;
  logic [15:0] p_m16;

  assign p_m16    = p_m[16] ? 16'hFFFF : p_m[15:0];
  assign stat_upd = (state == LOCKED) && en_in && good && !err_ev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      period_min <= 16'hFFFF;
      period_max <= 16'd0;
    end else if (clear) begin
      period_min <= 16'hFFFF;
      period_max <= 16'd0;
    end else if (stat_upd) begin
      if (p_m16 < period_min) begin
        period_min <= p_m16;
      end
      if (p_m16 > period_max) begin
        period_max <= p_m16;
      end
    end
  end
`else
  assign period_min = 16'd0;
  assign period_max = 16'd0;
`endif

endmodule
